// File: rtl/iccm_arbiter_pkg.sv
// Shared encodings for the ICCM port arbiter: sequencer states and read-response owner.
package iccm_arbiter_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } owner_e;

    localparam int unsigned CNT_W = 4;

    // ICCM is word addressed; byte offset is dropped without a misalignment check.
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/iccm_arbiter.sv
// Single-port ICCM arbiter: loader-only BOOT phase, then LSU/fetch sharing in RUN
// with a starvation guard for fetch and a one-cycle read response pipeline.
module iccm_arbiter
    import iccm_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX    = 4,
    parameter bit          BOOT_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    input  logic        ifu_flush,
    output logic        ifu_gnt,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,

    input  logic        lsu_req,
    input  logic [31:0] lsu_addr,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,

    input  logic        ldr_req,
    input  logic [31:0] ldr_addr,
    input  logic [31:0] ldr_wdata,
    output logic        ldr_gnt,
    input  logic        ldr_start,
    input  logic        ldr_done,

    output logic        boot_mode,

    output logic        iccm_en,
    output logic        iccm_we,
    output logic [31:0] iccm_addr,
    output logic [31:0] iccm_wdata,
    input  logic [31:0] iccm_rd_data
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam state_e           RST_STATE  = BOOT_ON_RESET ? ST_BOOT : ST_RUN;

    state_e           state, state_n;
    owner_e           owner, owner_n;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_n;
    logic             boot_pend, boot_pend_n;
    logic             want_boot;
    logic             fetch_forced;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RST_STATE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            boot_pend  <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            starve_cnt <= starve_cnt_n;
            boot_pend  <= boot_pend_n;
        end
    end

    always_comb begin
        state_n      = state;
        boot_pend_n  = boot_pend;
        starve_cnt_n = starve_cnt;
        ifu_gnt      = 1'b0;
        lsu_gnt      = 1'b0;
        ldr_gnt      = 1'b0;
        want_boot    = 1'b0;
        fetch_forced = 1'b0;

        // Grants are suppressed during reset so nothing reaches the macro.
        if (!rst) begin
            case (state)
                ST_BOOT: begin
                    ldr_gnt      = ldr_req;
                    starve_cnt_n = '0;
                    boot_pend_n  = 1'b0;
                    if (ldr_done)
                        state_n = ST_RUN;
                end
                ST_RUN: begin
                    fetch_forced = (starve_cnt == STARVE_LIM) && ifu_req;
                    // A pending return to BOOT freezes new reads so the pipe can drain.
                    if (!boot_pend) begin
                        if (ifu_req && (fetch_forced || !lsu_req))
                            ifu_gnt = 1'b1;
                        else if (lsu_req)
                            lsu_gnt = 1'b1;
                    end

                    if (ifu_req && !ifu_gnt)
                        starve_cnt_n = (starve_cnt == STARVE_LIM) ? starve_cnt
                                                                  : starve_cnt + 1'b1;
                    else
                        starve_cnt_n = '0;

                    want_boot = ldr_start || boot_pend;
                    if (want_boot) begin
                        if (owner == OWN_NONE && !ifu_gnt && !lsu_gnt) begin
                            state_n     = ST_BOOT;
                            boot_pend_n = 1'b0;
                        end else begin
                            boot_pend_n = 1'b1;
                        end
                    end
                end
                default: state_n = RST_STATE;
            endcase
        end
    end

    always_comb begin
        owner_n = OWN_NONE;
        if (ifu_gnt)
            owner_n = OWN_IFU;
        else if (lsu_gnt)
            owner_n = OWN_LSU;
    end

    always_comb begin
        iccm_en    = ifu_gnt || lsu_gnt || ldr_gnt;
        iccm_we    = ldr_gnt;
        iccm_wdata = ldr_wdata;
        iccm_addr  = word_addr(ifu_addr);
        if (ldr_gnt)
            iccm_addr = word_addr(ldr_addr);
        else if (lsu_gnt)
            iccm_addr = word_addr(lsu_addr);
    end

    // Flush only kills the fetch response; a same-cycle fetch grant is unaffected.
    assign ifu_rvalid = !rst && (owner == OWN_IFU) && !ifu_flush;
    assign lsu_rvalid = !rst && (owner == OWN_LSU);
    assign ifu_rdata  = iccm_rd_data;
    assign lsu_rdata  = iccm_rd_data;
    assign boot_mode  = (state == ST_BOOT);

endmodule

// File: tb/tb_iccm_arbiter.sv
// Directed bench for iccm_arbiter with a behavioural 1-cycle-latency ICCM.
module tb_iccm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req, ifu_flush, lsu_req, ldr_req, ldr_start, ldr_done;
    logic [31:0] ifu_addr, lsu_addr, ldr_addr, ldr_wdata;
    logic        ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid, ldr_gnt, boot_mode;
    logic [31:0] ifu_rdata, lsu_rdata;
    logic        iccm_en, iccm_we;
    logic [31:0] iccm_addr, iccm_wdata, iccm_rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    iccm_arbiter #(.STARVE_MAX(4), .BOOT_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_flush(ifu_flush),
        .ifu_gnt(ifu_gnt), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_gnt(lsu_gnt),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_start(ldr_start), .ldr_done(ldr_done),
        .boot_mode(boot_mode),
        .iccm_en(iccm_en), .iccm_we(iccm_we), .iccm_addr(iccm_addr),
        .iccm_wdata(iccm_wdata), .iccm_rd_data(iccm_rd_data)
    );

    always @(posedge clk) begin
        if (iccm_en) begin
            if (iccm_we) mem[iccm_addr[9:2]] <= iccm_wdata;
            else         iccm_rd_data <= mem[iccm_addr[9:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cyc;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[16] = 32'hCAFE0040;
        mem[64] = 32'h0BAD0100;
        iccm_rd_data = '0;
        rst = 1'b1;
        ifu_req = 0; ifu_flush = 0; lsu_req = 0; ldr_req = 1; ldr_start = 0; ldr_done = 0;
        ifu_addr = '0; lsu_addr = '0; ldr_addr = '0; ldr_wdata = '0;

        // reset: loader request present but nothing granted
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_boot_mode", 32'(boot_mode), 1);
        chk("rst_ldr_gnt",   32'(ldr_gnt), 0);
        chk("rst_en",        32'(iccm_en), 0);
        next_cyc;

        // 1: boot loading with fetch pending
        rst = 0; ifu_req = 1; ifu_addr = 32'h0;
        ldr_req = 1; ldr_addr = 32'h0; ldr_wdata = 32'h00000013;
        @(negedge clk);
        chk("boot_we0",   32'(iccm_we), 1);
        chk("boot_addr0", iccm_addr, 32'h0);
        chk("boot_ifu0",  32'(ifu_gnt), 0);
        next_cyc;
        ldr_addr = 32'h4; ldr_wdata = 32'h00100093;
        @(negedge clk);
        chk("boot_we1",   32'(iccm_we), 1);
        chk("boot_addr1", iccm_addr, 32'h4);
        chk("boot_wd1",   iccm_wdata, 32'h00100093);
        chk("boot_ifu1",  32'(ifu_gnt), 0);
        next_cyc;
        ldr_req = 0; ldr_done = 1;
        @(negedge clk);
        chk("done_we",    32'(iccm_we), 0);
        chk("done_mode",  32'(boot_mode), 1);
        next_cyc;

        // 2: RUN, fetch stream 0x0, 0x4
        ldr_done = 0; ifu_addr = 32'h0;
        @(negedge clk);
        chk("run_mode",   32'(boot_mode), 0);
        chk("f0_gnt",     32'(ifu_gnt), 1);
        chk("f0_addr",    iccm_addr, 32'h0);
        next_cyc;
        ifu_addr = 32'h4;
        @(negedge clk);
        chk("f1_gnt",     32'(ifu_gnt), 1);
        chk("f1_addr",    iccm_addr, 32'h4);
        chk("f0_rvalid",  32'(ifu_rvalid), 1);
        chk("f0_rdata",   ifu_rdata, 32'h00000013);
        next_cyc;
        ifu_req = 0;
        @(negedge clk);
        chk("f1_rvalid",  32'(ifu_rvalid), 1);
        chk("f1_rdata",   ifu_rdata, 32'h00100093);
        chk("idle_gnt",   32'(ifu_gnt), 0);
        next_cyc;

        // 3: starvation pattern, LSU x4 then fetch, repeated
        ifu_req = 1; lsu_req = 1; ifu_addr = 32'h8; lsu_addr = 32'hC;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("starve_ifu%0d", i), 32'(ifu_gnt), (i % 5 == 4) ? 1 : 0);
            chk($sformatf("starve_lsu%0d", i), 32'(lsu_gnt), (i % 5 == 4) ? 0 : 1);
            next_cyc;
        end
        ifu_req = 0; lsu_req = 0;
        next_cyc;

        // 4: flush kills response, same-cycle redirected fetch still returns
        ifu_req = 1; ifu_addr = 32'h0;
        @(negedge clk);
        chk("fl_gnt0", 32'(ifu_gnt), 1);
        next_cyc;
        ifu_addr = 32'h40; ifu_flush = 1;
        @(negedge clk);
        chk("fl_rvalid", 32'(ifu_rvalid), 0);
        chk("fl_gnt1",   32'(ifu_gnt), 1);
        chk("fl_addr1",  iccm_addr, 32'h40);
        next_cyc;
        ifu_req = 0; ifu_flush = 0;
        @(negedge clk);
        chk("fl_rvalid2", 32'(ifu_rvalid), 1);
        chk("fl_rdata2",  ifu_rdata, 32'hCAFE0040);
        next_cyc;

        // 5: misaligned LSU read
        lsu_req = 1; lsu_addr = 32'h103;
        @(negedge clk);
        chk("lsu_gnt",    32'(lsu_gnt), 1);
        chk("lsu_addr",   iccm_addr, 32'h100);
        chk("lsu_ifurv0", 32'(ifu_rvalid), 0);
        next_cyc;
        lsu_req = 0;
        @(negedge clk);
        chk("lsu_rvalid", 32'(lsu_rvalid), 1);
        chk("lsu_rdata",  lsu_rdata, 32'h0BAD0100);
        chk("lsu_ifurv1", 32'(ifu_rvalid), 0);
        next_cyc;

        // 6a: ldr_start with a fetch in flight waits for the pipe to drain
        ifu_req = 1; ifu_addr = 32'h0; ldr_start = 1;
        @(negedge clk);
        chk("st_gnt0",  32'(ifu_gnt), 1);
        chk("st_mode0", 32'(boot_mode), 0);
        next_cyc;
        ldr_start = 0;
        @(negedge clk);
        chk("st_rvalid", 32'(ifu_rvalid), 1);
        chk("st_gnt1",   32'(ifu_gnt), 0);
        chk("st_mode1",  32'(boot_mode), 0);
        next_cyc;
        @(negedge clk);
        chk("st_gnt2",  32'(ifu_gnt), 0);
        chk("st_mode2", 32'(boot_mode), 0);
        next_cyc;
        ldr_req = 1; ldr_addr = 32'h8; ldr_wdata = 32'h12345678;
        @(negedge clk);
        chk("st_mode3",  32'(boot_mode), 1);
        chk("st_ifu3",   32'(ifu_gnt), 0);
        chk("st_ldr3",   32'(ldr_gnt), 1);
        next_cyc;
        ldr_req = 0; ldr_done = 1;
        next_cyc;

        // 6b: reset mid-stream drops response and clears the starvation count
        ldr_done = 0; ifu_req = 1; lsu_req = 1;
        @(negedge clk);
        chk("mr_lsu0", 32'(lsu_gnt), 1);
        next_cyc;
        next_cyc;
        rst = 1;
        @(negedge clk);
        chk("mr_rst_lsurv", 32'(lsu_rvalid), 0);
        chk("mr_rst_gnt",   32'(lsu_gnt | ifu_gnt), 0);
        next_cyc;
        rst = 0; ifu_req = 0; lsu_req = 0;
        @(negedge clk);
        chk("mr_post_lsurv", 32'(lsu_rvalid), 0);
        chk("mr_post_ifurv", 32'(ifu_rvalid), 0);
        chk("mr_post_mode",  32'(boot_mode), 1);
        ldr_done = 1;
        next_cyc;
        ldr_done = 0; ifu_req = 1; lsu_req = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("mr_ifu%0d", i), 32'(ifu_gnt), (i == 4) ? 1 : 0);
            next_cyc;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
